// File: rtl/core_pkg.sv
// core_pkg: shared divider types, XLEN constant and corner-case result helper.
package core_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

    // Result for divide-by-zero (div0=1) or signed overflow (div0=0).
    function automatic logic [XLEN-1:0] corner_result(div_op_e op, logic [XLEN-1:0] a, logic div0);
        return op[1] ? (div0 ? a : '0) : (div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});
    endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU) with regfile write-back port.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish one cycle after accept.
module div_unit
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_addr,
    output logic            wb_en
);
    div_state_e      r_state, w_next;
    logic            r_rem_sel, r_neg_q, r_neg_r, r_div0;
    logic [4:0]      r_rd, r_cnt, r_wb_addr;
    logic [XLEN-1:0] r_quo, r_rem, r_dvs, r_result;

    div_op_e         w_op;
    logic            w_signed, w_a_neg, w_b_neg, w_div0, w_accept, w_keep, w_corner;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_quo_n, w_rem_n, w_q, w_r, w_res;
    logic [XLEN:0]   w_sh, w_diff;

    assign w_op     = div_op_e'(op);
    assign w_signed = (w_op == DIV) || (w_op == REM);
    assign w_a_neg  = w_signed & rs1_val[XLEN-1];
    assign w_b_neg  = w_signed & rs2_val[XLEN-1];
    assign w_abs_a  = w_a_neg ? -rs1_val : rs1_val;
    assign w_abs_b  = w_b_neg ? -rs2_val : rs2_val;
    assign w_div0   = rs2_val == '0;
    assign w_accept = (r_state == IDLE) && start && !flush;
`ifdef DIV_EARLY_OUT_EN
    assign w_corner = w_div0 || (w_signed && rs1_val == {1'b1, {(XLEN-1){1'b0}}} && rs2_val == '1);
`else
    assign w_corner = 1'b0;
`endif

    // One restoring step: remainder always stays below the divisor, so 33 bits suffice.
    assign w_sh    = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_sh - {1'b0, r_dvs};
    assign w_keep  = !w_diff[XLEN];
    assign w_rem_n = w_keep ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
    assign w_quo_n = {r_quo[XLEN-2:0], w_keep};

    // Signed overflow falls out of the datapath; only the div-by-zero quotient needs forcing.
    assign w_q   = r_div0 ? '1 : (r_neg_q ? -w_quo_n : w_quo_n);
    assign w_r   = r_neg_r ? -w_rem_n : w_rem_n;
    assign w_res = r_rem_sel ? w_r : w_q;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_corner ? DONE : CALC) : IDLE;
            CALC:    w_next = flush ? IDLE : (r_cnt == 5'd0 ? DONE : CALC);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_wb_addr <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rem_sel <= op[1];
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_div0    <= w_div0;
                r_rd      <= rd_addr;
                r_quo     <= w_abs_a;
                r_dvs     <= w_abs_b;
                r_rem     <= '0;
                r_cnt     <= 5'd31;
                if (w_corner) begin
                    r_result  <= corner_result(w_op, rs1_val, w_div0);
                    r_wb_addr <= rd_addr;
                end
            end else if (r_state == CALC) begin
                r_rem <= w_rem_n;
                r_quo <= w_quo_n;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd0 && !flush) begin
                    r_result  <= w_res;
                    r_wb_addr <= r_rd;
                end
            end
        end
    end

    assign busy    = r_state != IDLE;
    assign done    = r_state == DONE;
    assign result  = r_result;
    assign wb_addr = r_wb_addr;
    assign wb_en   = done && (r_wb_addr != '0);
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (honours DIV_EARLY_OUT_EN for corner latency).
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int CORNER_LAT = 1;
`else
    localparam int CORNER_LAT = 33;
`endif

    div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .rd_addr(rd_addr), .flush(flush), .busy(busy),
        .done(done), .result(result), .wb_addr(wb_addr), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a request in cycle 0; returns in cycle 1 (#1 after edge 0).
    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rs1_val = 32'hDEADBEEF; rs2_val = 32'h0BADF00D;
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int lat, nbusy;
        go(o, a, b, rd);
        lat = 1; nbusy = 0;
        while (!done && lat < 45) begin
            nbusy += busy ? 1 : 0;
            @(posedge clk); #1 lat++;
        end
        nbusy += busy ? 1 : 0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, nbusy, exp_lat);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, rd});
        chk({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, rd != 5'd0});
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int ndone, nwb;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 33);
        run("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFD, 33);
        run("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF, 33);
        run("rem_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 5'd9, 32'd1, 33);
        run("div_5_0", 2'b00, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, CORNER_LAT);
        run("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd11, 32'd5, CORNER_LAT);
        run("rem_m5_0", 2'b10, 32'hFFFFFFFB, 32'd0, 5'd12, 32'hFFFFFFFB, CORNER_LAT);
        run("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, CORNER_LAT);
        run("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, CORNER_LAT);
        run("divu_big", 2'b01, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 33);

        // rd=0 with a second start in cycle 5 that must be ignored
        go(2'b01, 32'd9, 32'd3, 5'd0);
        repeat (4) @(posedge clk);
        #1 op = 2'b01; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0; nwb = 0;
        repeat (45) begin
            ndone += done ? 1 : 0;
            nwb += wb_en ? 1 : 0;
            @(posedge clk); #1;
        end
        chk("rd0_done_count", ndone, 32'd1);
        chk("rd0_wb_en_count", nwb, 32'd0);
        chk("rd0_result", result, 32'd3);
        chk("rd0_wb_addr", {27'd0, wb_addr}, 32'd0);

        // flush during cycle 10
        go(2'b01, 32'd1000, 32'd10, 5'd20);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy_c11", {31'd0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin
            ndone += done ? 1 : 0;
            @(posedge clk); #1;
        end
        chk("flush_no_done", ndone, 32'd0);
        chk("flush_result_kept", result, 32'd3);
        chk("flush_wb_addr_kept", {27'd0, wb_addr}, 32'd0);

        // flush together with start in IDLE: start dropped
        @(negedge clk);
        op = 2'b01; rs1_val = 32'd50; rs2_val = 32'd5; rd_addr = 5'd4; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset in cycle 20 of an operation
        go(2'b01, 32'd1000, 32'd10, 5'd21);
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            ndone += done ? 1 : 0;
        end
        chk("arst_no_done", ndone, 32'd0);

        run("post_rst_divu", 2'b01, 32'd9, 32'd3, 5'd1, 32'd3, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider for the core's execute stage: takes the two register-file read operands (rd1/rd2) plus a destination index, runs a radix-2 restoring division over 32 cycles and presents quotient or remainder on a write-back port that drives regfile wd3/a3/we3. It implements DIV, DIVU, REM and REMU with the RISC-V corner-case results. Start/busy/done handshake; the pipeline stalls while busy.

## Interface

- XLEN, 32, operand/result width (only 32 supported)
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request; accepted only when busy=0
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_val  in  XLEN  dividend (regfile rd1)
- rs2_val  in  XLEN  divisor (regfile rd2)
- rd_addr  in  5  destination register index
- flush  in  1  synchronous abort of in-flight operation
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered quotient/remainder (to wd3)
- wb_addr  out  5  latched rd_addr (to a3)
- wb_en  out  1  done && wb_addr!=0 (to we3)

## Operation

- FSM states: IDLE, CALC, DONE. IDLE -start-> CALC; CALC -count==0-> DONE; DONE -> IDLE unconditionally.
- On accept: latch op, rd_addr, sign flags; load |rs1| and |rs2| (signed ops) or raw values (unsigned); remainder reg = 0; 5-bit counter = 31.
- CALC, per cycle: shift {rem,quo} left 1, trial subtract divisor from rem (33-bit), keep if non-negative and set quo LSB=1; counter decrements.
- DONE: quotient negated if signed op and operand signs differ; remainder takes dividend sign; select per op into result; done=1.
- Divide-by-zero: quotient 0xFFFFFFFF, remainder = rs1_val (unmodified).
- Signed overflow (0x80000000 / 0xFFFFFFFF, op DIV/REM): quotient 0x80000000, remainder 0.
- Corner results override the datapath result in DONE.
- start while busy=1 ignored (no queueing).
- flush in CALC or DONE: next state IDLE, no done, result/wb_addr unchanged. flush with start in IDLE: flush wins, start dropped.
- rd_addr=0: operation runs, done pulses, wb_en stays 0.

## Timing

- Reset: state IDLE, busy=0, done=0, wb_en=0, result=0, wb_addr=0, counter=0.
- rst_n asserted mid-operation: immediate abort to reset values; no done after release.
- Start sampled at edge 0: busy=1 from cycle 1; CALC cycles 1-32; done/wb_en high in cycle 33; busy=0 in cycle 34; next start accepted at edge ending cycle 34 earliest.
- result and wb_addr hold their value after done until the next DONE.
- Operands need only be valid in the start cycle.

## Configuration

- DIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow detected at accept; FSM goes IDLE->DONE, done in cycle 1 (latency 1).
- Not defined: corner cases traverse full CALC, done in cycle 33; result values identical in both builds.

## Structure

- core_pkg: XLEN constant, div_op_e enum (DIV, DIVU, REM, REMU), div_state_e enum (IDLE, CALC, DONE).
- No sub-module; single file, iteration step in one always_ff, sign fix-up/corner select combinational before result register.

## Test plan

- DIVU 100/7 -> result 14 in cycle 33; REMU 100/7 -> 2; busy high cycles 1-33.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/0xFFFFFFFE -> 1.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; done cycle 1 with DIV_EARLY_OUT_EN, cycle 33 without.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- rd_addr=0, DIVU 9/3 -> done pulses, wb_en=0; second start at cycle 5 ignored, single done.
- flush at cycle 10 -> busy=0 cycle 11, no done; rst_n low at cycle 20 of new op -> outputs zero, no done after release.
